// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
//   Bundles the data-side inputs and the board-pin outputs of the 7-segment
//   scan driver.
//
//   Handshake: there is no ready signal. `load` is a single-cycle strobe.
//   On every rising clk edge where load=1, data_in/dp_in/blank_mask are
//   captured, and the driver always accepts them. The producer may hold
//   `load` high for several cycles. Each such cycle is a fresh capture, and
//   the last one wins.
//
//   Signals (NUM_DIGITS = digit count):
//     enable      master->slave  1             scan on / all digits dark
//     load        master->slave  1             capture strobe
//     data_in     master->slave  4*NUM_DIGITS  packed BCD, nibble k on an[k]
//     dp_in       master->slave  NUM_DIGITS    decimal points, 1 = lit
//     blank_mask  master->slave  NUM_DIGITS    1 = force digit k dark
//     seg         slave->master  7             {a..g}, active low
//     dp          slave->master  1             decimal point, active low
//     an          slave->master  NUM_DIGITS    digit enables, active low
//     frame_done  slave->master  1             pulse on scan wrap
// ---------------------------------------------------------------------------
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output enable, load, data_in, dp_in, blank_mask,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  enable, load, data_in, dp_in, blank_mask,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits that
//   share one segment bus. A load strobe captures a packed BCD word into a
//   shadow register. The shadow is copied into the active (displayed)
//   register only when the scan wraps, so a frame never shows a torn value.
//   Each digit stays lit for REFRESH_DIV clocks.
//
//   Parameters:
//     NUM_DIGITS   digits driven, 1..16
//     REFRESH_DIV  clocks per digit slot, >= 2
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg7_scan_if.slave. It carries enable, load, data_in, dp_in
//            and blank_mask as inputs, and seg, dp, an and frame_done as
//            outputs. All outputs are registered.
//
//   Build option:
//     SEG7_HEX_DIGITS_EN  when defined, nibbles 10..15 show A b C d E F.
//                         When undefined, they blank the segments, but the
//                         digit's anode is still driven.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DARK   = 7'h7F;

  // Segment decode, {a,b,c,d,e,f,g}, active low.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_DARK;
    case (nib)
      4'd0: s = 7'b0000001;
      4'd1: s = 7'b1001111;
      4'd2: s = 7'b0010010;
      4'd3: s = 7'b0000110;
      4'd4: s = 7'b1001100;
      4'd5: s = 7'b0100100;
      4'd6: s = 7'b0100000;
      4'd7: s = 7'b0001111;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0000100;
`ifdef SEG7_HEX_DIGITS_EN
      4'd10: s = 7'b0001000;
      4'd11: s = 7'b1100000;
      4'd12: s = 7'b0110001;
      4'd13: s = 7'b1000010;
      4'd14: s = 7'b0110000;
      4'd15: s = 7'b0111000;
`else
      default: s = SEG_DARK;
`endif
    endcase
    return s;
  endfunction

  // Scan counters
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  // Shadow (last loaded) and active (being displayed) copies
  logic [DW-1:0]         sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_mask_q, sh_mask_d;
  logic [DW-1:0]         ac_data_q, ac_data_d;
  logic [NUM_DIGITS-1:0] ac_dp_q, ac_dp_d;
  logic [NUM_DIGITS-1:0] ac_mask_q, ac_mask_d;

  // Registered pin outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic       tc;
  logic       wrap;
  logic [3:0] nib;

  assign tc   = bus.enable && (presc_q == PRESC_LAST);
  assign wrap = tc && (idx_q == IDX_LAST);
  assign nib  = ac_data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_mask_d = sh_mask_q;
    ac_data_d = ac_data_q;
    ac_dp_d   = ac_dp_q;
    ac_mask_d = ac_mask_q;

    // Both counters freeze while disabled, so the scan resumes mid-slot.
    if (bus.enable) begin
      presc_d = tc ? '0 : presc_q + 1'b1;
    end
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    if (wrap) begin
      ac_data_d = sh_data_q;
      ac_dp_d   = sh_dp_q;
      ac_mask_d = sh_mask_q;
    end

    if (bus.load) begin
      sh_data_d = bus.data_in;
      sh_dp_d   = bus.dp_in;
      sh_mask_d = bus.blank_mask;
      // A load on the wrap edge bypasses the shadow. Otherwise the next
      // frame would show the old shadow contents. While the scan is off,
      // no frame is in flight, so the active copy is updated immediately.
      if (wrap || !bus.enable) begin
        ac_data_d = bus.data_in;
        ac_dp_d   = bus.dp_in;
        ac_mask_d = bus.blank_mask;
      end
    end
  end

  // Outputs are built from this cycle's index and active copy, and appear
  // one clock later.
  always_comb begin
    seg_d = SEG_DARK;
    dp_d  = 1'b1;
    an_d  = '1;
    fd_d  = 1'b0;
    if (bus.enable) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      fd_d = wrap;
      // A masked digit keeps its anode low, so the scan duty stays uniform.
      if (!ac_mask_q[idx_q]) begin
        seg_d = decode(nib);
        dp_d  = ~ac_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_mask_q <= '0;
      ac_data_q <= '0;
      ac_dp_q   <= '0;
      ac_mask_q <= '0;
      seg_q     <= SEG_DARK;
      dp_q      <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_mask_q <= sh_mask_d;
      ac_data_q <= ac_data_d;
      ac_dp_q   <= ac_dp_d;
      ac_mask_q <= ac_mask_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4 and REFRESH_DIV=4.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt;
  int total_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The scan position is a single count of enabled cycles within a frame.
  // The slot number is that count divided by REFRESH_DIV.
  logic [6:0]  dec_tab [16];
  int          m_t;
  logic [15:0] sh_data, ac_data;
  logic [3:0]  sh_dp, ac_dp, sh_mask, ac_mask;

  initial begin
    dec_tab[0] = 7'b0000001; dec_tab[1] = 7'b1001111;
    dec_tab[2] = 7'b0010010; dec_tab[3] = 7'b0000110;
    dec_tab[4] = 7'b1001100; dec_tab[5] = 7'b0100100;
    dec_tab[6] = 7'b0100000; dec_tab[7] = 7'b0001111;
    dec_tab[8] = 7'b0000000; dec_tab[9] = 7'b0000100;
`ifdef SEG7_HEX_DIGITS_EN
    dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b1100000;
    dec_tab[12] = 7'b0110001; dec_tab[13] = 7'b1000010;
    dec_tab[14] = 7'b0110000; dec_tab[15] = 7'b0111000;
`else
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'h7F;
`endif
  end

  task automatic model_reset();
    m_t = 0;
    sh_data = '0; ac_data = '0;
    sh_dp = '0; ac_dp = '0;
    sh_mask = '0; ac_mask = '0;
  endtask

  // Returns what the outputs must show after the coming edge, then advances.
  task automatic model_step(output logic [6:0] e_seg, output logic e_dp,
                            output logic [3:0] e_an, output logic e_fd);
    int         k;
    logic [3:0] nibv;
    logic       wrapv;
    k = m_t / RD;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    if (bus.enable) begin
      e_an = ~(4'b0001 << k);
      e_fd = (m_t == FRAME - 1);
      if (!ac_mask[k]) begin
        nibv  = 4'((ac_data >> (4 * k)) & 16'hF);
        e_seg = dec_tab[nibv];
        e_dp  = ~ac_dp[k];
      end
    end
    wrapv = bus.enable && (m_t == FRAME - 1);
    if (wrapv) begin
      ac_data = sh_data; ac_dp = sh_dp; ac_mask = sh_mask;
    end
    if (bus.load) begin
      sh_data = bus.data_in; sh_dp = bus.dp_in; sh_mask = bus.blank_mask;
      if (wrapv || !bus.enable) begin
        ac_data = bus.data_in; ac_dp = bus.dp_in; ac_mask = bus.blank_mask;
      end
    end
    if (bus.enable) m_t = (m_t + 1) % FRAME;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle. The inputs were set before the call. The outputs are
  // compared to the model 1 time unit after the edge, and the load strobe
  // is then dropped.
  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_fd;
    model_step(e_seg, e_dp, e_an, e_fd);
    @(posedge clk);
    #1;
    check("model_seg", {25'b0, bus.seg}, {25'b0, e_seg});
    check("model_dp", {31'b0, bus.dp}, {31'b0, e_dp});
    check("model_an", {28'b0, bus.an}, {28'b0, e_an});
    check("model_frame_done", {31'b0, bus.frame_done}, {31'b0, e_fd});
    bus.load = 1'b0;
  endtask

  // Assert reset away from the clock edge, check the values seen while it
  // is held, then release it 1 time unit after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_seg", {25'b0, bus.seg}, 32'h7F);
    check("rst_dp", {31'b0, bus.dp}, 32'h1);
    check("rst_an", {28'b0, bus.an}, 32'hF);
    check("rst_frame_done", {31'b0, bus.frame_done}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    bus.data_in = d; bus.dp_in = p; bus.blank_mask = m; bus.load = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dpv;
    logic [3:0]      mask;
    logic [3:0][6:0] segs;   // expected seg per slot, index = slot
    logic [3:0]      dpo;    // expected dp pin per slot
  } vec_t;

  vec_t vecs [4];

  initial begin
    int          fd_cnt;
    logic [3:0]  exp_an_v;
    logic [6:0]  exp_seg_v;
    logic        exp_dp_v;

    vecs[0] = '{16'h4321, 4'h0, 4'h0,
                {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111}, 4'hF};
    vecs[1] = '{16'h8765, 4'h0, 4'h0,
                {7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100}, 4'hF};
    vecs[2] = '{16'h9090, 4'b0001, 4'b0100,
                {7'b0000100, 7'h7F, 7'b0000100, 7'b0000001}, 4'b1110};
`ifdef SEG7_HEX_DIGITS_EN
    vecs[3] = '{16'hFA00, 4'h0, 4'h0,
                {7'b0111000, 7'b0001000, 7'b0000001, 7'b0000001}, 4'hF};
`else
    vecs[3] = '{16'hFA00, 4'h0, 4'h0,
                {7'h7F, 7'h7F, 7'b0000001, 7'b0000001}, 4'hF};
`endif

    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.load = 1'b0;
    bus.data_in = '0; bus.dp_in = '0; bus.blank_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Table: load while the scan is off, then run one frame from slot 0.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      bus.enable = 1'b0;
      load_now(vecs[r].data, vecs[r].dpv, vecs[r].mask);
      tick();
      bus.enable = 1'b1;
      for (int c = 1; c <= FRAME; c++) begin
        int s;
        tick();
        s = (c - 1) / RD;
        exp_an_v  = ~(4'b0001 << s);
        exp_seg_v = vecs[r].segs[s];
        exp_dp_v  = vecs[r].dpo[s];
        check("tbl_seg", {25'b0, bus.seg}, {25'b0, exp_seg_v});
        check("tbl_dp", {31'b0, bus.dp}, {31'b0, exp_dp_v});
        check("tbl_an", {28'b0, bus.an}, {28'b0, exp_an_v});
      end
    end

    // Reset in the middle of a scan; the scan restarts on digit 0.
    bus.enable = 1'b1;
    repeat (7) tick();
    do_reset();
    tick();
    check("post_rst_an", {28'b0, bus.an}, 32'hE);

    // frame_done pulses once every 16 enabled clocks.
    do_reset();
    fd_cnt = 0;
    for (int c = 1; c <= 3 * FRAME; c++) begin
      tick();
      if (bus.frame_done) begin
        fd_cnt++;
        check("fd_position", c % FRAME, 0);
      end
    end
    check("fd_count", fd_cnt, 3);

    // A load one cycle before the wrap only reaches the shadow. A load on
    // the wrap edge itself goes straight to the next frame.
    do_reset();
    bus.enable = 1'b0;
    load_now(16'h4321, 4'h0, 4'h0);
    tick();
    bus.enable = 1'b1;
    repeat (14) tick();
    load_now(16'h9999, 4'h0, 4'h0);
    tick();                                  // edge 15
    tick();                                  // edge 16, the wrap
    check("stale_slot3", {25'b0, bus.seg}, {25'b0, 7'b1001100});
    tick();
    check("shadow_next_frame", {25'b0, bus.seg}, {25'b0, 7'b0000100});
    repeat (14) tick();                      // edges 18..31
    load_now(16'h8888, 4'h0, 4'h0);
    tick();                                  // edge 32, the wrap
    check("pre_bypass_slot3", {25'b0, bus.seg}, {25'b0, 7'b0000100});
    tick();
    check("bypass_slot0", {25'b0, bus.seg}, {25'b0, 7'b0000000});

    // Disable in the middle of a slot; the same digit finishes its count.
    do_reset();
    bus.enable = 1'b0;
    load_now(16'h4321, 4'h0, 4'h0);
    tick();
    bus.enable = 1'b1;
    repeat (6) tick();
    bus.enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("dis_an", {28'b0, bus.an}, 32'hF);
      check("dis_seg", {25'b0, bus.seg}, 32'h7F);
      check("dis_fd", {31'b0, bus.frame_done}, 32'h0);
    end
    bus.enable = 1'b1;
    tick();
    check("resume_an_a", {28'b0, bus.an}, 32'hD);
    tick();
    check("resume_an_b", {28'b0, bus.an}, 32'hD);
    tick();
    check("resume_an_c", {28'b0, bus.an}, 32'hB);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 6) == 0) begin
        load_now(16'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
